// File: rtl/conv_pkg.sv
// Shared widths, default image geometry and kernel indices for the 3x3 convolution filter.
package conv_pkg;

  localparam int PIX_W    = 8;
  localparam int COEF_W   = 8;
  localparam int PROD_W   = 17;
  localparam int ROWSUM_W = 19;
  localparam int SUM_W    = 21;

  localparam int DEF_IMG_W = 256;
  localparam int DEF_IMG_H = 32;

  localparam int NUM_COEF = 9;
  localparam int K1 = 0;
  localparam int K2 = 1;
  localparam int K3 = 2;
  localparam int K4 = 3;
  localparam int K5 = 4;
  localparam int K6 = 5;
  localparam int K7 = 6;
  localparam int K8 = 7;
  localparam int K9 = 8;

  // Centre tap of the identity kernel; 1<<SHIFT does not fit a signed byte beyond 6.
  function automatic logic signed [COEF_W-1:0] identity_centre(input int shift);
    if (shift >= COEF_W - 1)
      return 8'sd127;
    else
      return COEF_W'(1 << shift);
  endfunction

endpackage

// File: rtl/conv_sat_round.sv
// Combinational round-half-up, arithmetic right shift and clamp of the kernel sum to an 8-bit pixel.
module conv_sat_round
  import conv_pkg::*;
#(
  parameter int SHIFT = 4
) (
  input  logic signed [SUM_W-1:0] sum,
  output logic        [PIX_W-1:0] pix
);

  // One extra bit of headroom so the rounding offset can never wrap the sum.
  localparam logic signed [SUM_W:0] RND = (SUM_W+1)'((2 ** SHIFT) / 2);

  logic signed [SUM_W:0] rounded;
  logic signed [SUM_W:0] shifted;

  always_comb begin
    rounded = (SUM_W+1)'(sum) + RND;
    shifted = rounded >>> SHIFT;
    if (shifted[SUM_W])
      pix = '0;
    else if (|shifted[SUM_W-1:PIX_W])
      pix = '1;
    else
      pix = shifted[PIX_W-1:0];
  end

endmodule

// File: rtl/conv3x3_filter.sv
// Three-stage 3x3 convolution: multiply by a programmable kernel, adder tree, round/saturate,
// plus output column/row tracking that flags row and frame ends.
module conv3x3_filter
  import conv_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int SHIFT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              win_valid,
  input  logic [PIX_W-1:0]  p1,
  input  logic [PIX_W-1:0]  p2,
  input  logic [PIX_W-1:0]  p3,
  input  logic [PIX_W-1:0]  p4,
  input  logic [PIX_W-1:0]  p5,
  input  logic [PIX_W-1:0]  p6,
  input  logic [PIX_W-1:0]  p7,
  input  logic [PIX_W-1:0]  p8,
  input  logic [PIX_W-1:0]  p9,
  input  logic              coef_we,
  input  logic [3:0]        coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic [PIX_W-1:0]  pix_out,
  output logic              out_valid,
  output logic              row_end,
  output logic              frame_done
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic signed [COEF_W-1:0] K5_IDENT = identity_centre(SHIFT);

  logic        [PIX_W-1:0]    pix     [NUM_COEF];
  logic signed [COEF_W-1:0]   coef    [NUM_COEF];
  logic signed [PROD_W-1:0]   prod    [NUM_COEF];
  logic signed [ROWSUM_W-1:0] row_sum [3];
  logic signed [SUM_W-1:0]    total;
  logic        [PIX_W-1:0]    sat_pix;
  logic                       v1;
  logic                       v2;
  logic        [COL_W-1:0]    col;
  logic        [ROW_W-1:0]    row;

  always_comb begin
    pix[K1] = p1;
    pix[K2] = p2;
    pix[K3] = p3;
    pix[K4] = p4;
    pix[K5] = p5;
    pix[K6] = p6;
    pix[K7] = p7;
    pix[K8] = p8;
    pix[K9] = p9;
  end

  // Writes land at the clock edge, so a window sampled on the same edge still sees the old kernel.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_COEF; i++)
        coef[i] <= (i == K5) ? K5_IDENT : '0;
    end else if (coef_we && coef_addr < 4'(NUM_COEF)) begin
      coef[coef_addr] <= coef_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      v1 <= win_valid;
      v2 <= v1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_COEF; i++)
      prod[i] <= PROD_W'($signed({1'b0, pix[i]})) * PROD_W'(coef[i]);
    for (int r = 0; r < 3; r++)
      row_sum[r] <= ROWSUM_W'(prod[3*r]) + ROWSUM_W'(prod[3*r+1]) + ROWSUM_W'(prod[3*r+2]);
  end

  always_comb begin
    total = SUM_W'(row_sum[0]) + SUM_W'(row_sum[1]) + SUM_W'(row_sum[2]);
  end

  conv_sat_round #(
    .SHIFT (SHIFT)
  ) u_sat_round (
    .sum (total),
    .pix (sat_pix)
  );

  // col/row name the position of the pixel about to leave stage 3, so the end flags register with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_out    <= '0;
      out_valid  <= 1'b0;
      row_end    <= 1'b0;
      frame_done <= 1'b0;
      col        <= '0;
      row        <= '0;
    end else begin
      out_valid  <= v2;
      row_end    <= v2 && (col == COL_LAST);
      frame_done <= v2 && (col == COL_LAST) && (row == ROW_LAST);
      if (v2) begin
        pix_out <= sat_pix;
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/conv3x3_filter.md
Name: conv3x3_filter

Overview:
- Consumes the nine-pixel 3x3 window stream from the padded line/frame memory stage (one window per cycle, raster order over a 256x32 output image) and produces one filtered 8-bit pixel per window.
- 3-stage pipeline: signed multiply by a programmable 3x3 kernel, adder tree, then round/shift/saturate.
- Also counts output pixels and flags row end and frame end for the downstream write-back stage.

Parameters:
- IMG_W, 256, output pixels per row.
- IMG_H, 32, output rows per frame.
- SHIFT, 4, normalisation right-shift applied to the kernel sum (0..8).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- win_valid  in  1  window p1..p9 valid this cycle (memory read strobe delayed by one cycle to match its registered outputs).
- p1..p9  in  8 each  unsigned window pixels, row-major (p1 top-left, p5 centre, p9 bottom-right).
- coef_we  in  1  kernel coefficient write strobe.
- coef_addr  in  4  coefficient index 0..8 (0 -> k1 ... 8 -> k9); values 9..15 are ignored.
- coef_data  in  8  signed two's-complement coefficient.
- pix_out  out  8  filtered pixel.
- out_valid  out  1  pix_out valid.
- row_end  out  1  high with the last pixel of each row.
- frame_done  out  1  high with the last pixel of the frame.

Behaviour:
- Reset:
  - All outputs are 0.
  - Pipeline valid bits and pixel counter are cleared.
  - Coefficients are set to the identity kernel: k5 = 1<<SHIFT (saturating at 127 if SHIFT=7 or 8), all others 0.
  - Reset asserted mid-frame discards all in-flight windows; no out_valid on the following cycle.
- Coefficient write:
  - Registered; takes effect for windows entering stage 1 on the cycle after the write.
  - A write in the same cycle as win_valid does not affect that window.
- Stage 1 (cycle N+1 after a window is accepted at N): nine products, each {1'b0,pixel} (9b signed) times coef (8b signed), giving a 17-bit signed product.
- Stage 2 (N+2): three row sums, 19-bit signed.
- Stage 3 (N+3): total sum is 21-bit signed.
  - If SHIFT>0, add 1<<(SHIFT-1).
  - Arithmetic right shift by SHIFT.
  - Saturate: result <0 -> 0, >255 -> 255.
  - Register the result into pix_out.
- Latency: 3 cycles from win_valid to out_valid.
- Throughput: one window per cycle, no stall and no back-pressure.
- Bubbles: gaps in win_valid propagate as gaps in out_valid. pix_out holds its last value when out_valid=0.
- Counters:
  - col (8b, 0..IMG_W-1) and row (5b, 0..IMG_H-1) advance on each out_valid.
  - row_end = out_valid & col==IMG_W-1.
  - frame_done = row_end & row==IMG_H-1.
  - Both counters wrap to 0 after frame_done; the next frame starts cleanly with no reset needed.
- row_end and frame_done are single-cycle pulses aligned with out_valid and registered with it (no combinational path from inputs).
- No state machine beyond the valid shift register and counters; a window stream longer than one frame simply begins the next frame.

Decomposition:
- Shared package conv_pkg holds:
  - PIX_W=8, COEF_W=8, PROD_W=17, SUM_W=21.
  - Default IMG_W/IMG_H.
  - The coefficient index constants.
- One natural sub-module: conv_sat_round (SUM_W in, SHIFT parameter, 8-bit saturated out, purely combinational), used in stage 3.

Test Plan:
- Identity: after reset, window with p5=100 and all others 37, win_valid for 1 cycle -> exactly 3 cycles later out_valid=1 and pix_out=100; out_valid=0 on the cycles either side.
- Box blur: write k1..k9=1, SHIFT=4, all pixels 160 -> (1440+8)>>4 = pix_out 90.
- Positive saturation: k5=127, others -1, p5=255, others 0 -> 32385+8>>4 = 2024 -> pix_out 255. Negative saturation: k5=8, others -1, p5=0, others 255 -> -2032>>4 -> pix_out 0.
- Frame counting: 8192 back-to-back windows with random bubbles inserted:
  - row_end pulses exactly 32 times, on outputs 256, 512, ...
  - frame_done is a single pulse on output 8192.
  - Output 8193 starts col=0,row=0 (row_end again after 256 more).
- Coefficient timing: change k5 from 16 to 32 in the same cycle as window A (p5=10) and before window B (p5=10), back-to-back -> A outputs 10, B outputs 20.
- Reset mid-operation: 5 windows in flight, assert rst for 1 cycle:
  - No out_valid for those windows.
  - Coefficients revert to identity.
  - The next frame's first row_end occurs after 256 fresh outputs.
